mem_sys_ctrl: RTL
=================

MEM_SYS_CTRL -- requirements
Module: mem_sys_ctrl

Interface
REQ-001 SHALL have ports clk (input, 1: the single clock, rising edge) and rst (input, 1: asynchronous, active-low reset).
REQ-002 SHALL have the processor-side inputs Addr (16), DataIn (16), Rd (1) and Wr (1): byte address, store data, load request and store request.
REQ-003 SHALL have the processor-side outputs DataOut (16), Done (1), Stall (1), CacheHit (1) and err (1).
REQ-004 SHALL have the memory-side outputs mem_addr (16), mem_data_out (16), mem_rd (1) and mem_wr (1).
REQ-005 SHALL have the memory-side inputs mem_data_in (16) and mem_stall (1), where mem_stall means the targeted bank is busy.
REQ-006 SHALL have the statistics outputs hit_count (16) and miss_count (16).

Function
REQ-007 SHALL implement a direct-mapped, write-back, write-allocate cache: 16 lines x 4 words, tag=Addr[15:7], index=Addr[6:3], word offset=Addr[2:1], with per-line valid and dirty bits.
REQ-008 SHALL use the FSM states IDLE, COMPARE, WRITEBACK, ALLOCATE and DONE.
REQ-009 SHALL sample a request only in IDLE, register Addr, DataIn, Rd and Wr, and move to COMPARE on the next edge.
REQ-010 SHALL treat a COMPARE hit (valid and tag match) as: Done=1 and CacheHit=1 in that same cycle; a load drives DataOut; a store writes the word and sets dirty; next state is IDLE (hit latency 1 cycle).
REQ-011 SHALL on a COMPARE miss go to WRITEBACK if the victim line is valid and dirty, otherwise to ALLOCATE.
REQ-012 SHALL in WRITEBACK issue 4 consecutive mem_wr for words 0..3 at {victim tag, index, word, 1'b0}, then go to ALLOCATE.
REQ-013 SHALL in ALLOCATE issue 4 consecutive mem_rd for words 0..3, capture mem_data_in 2 cycles after each issue, then install the tag, set valid, clear dirty and go to DONE.
REQ-014 SHALL in DONE perform the original access (a store merges DataIn and sets dirty) and assert Done=1 with CacheHit=0 for one cycle, then return to IDLE.
REQ-015 SHALL give a clean miss Done 8 cycles after the request cycle and a dirty miss 12, with zero mem_stall.
REQ-016 SHALL, while mem_stall=1, hold the issue counter and keep the mem_rd/mem_wr request asserted until mem_stall=0; capture timing counts from the accepted issue.
REQ-017 SHALL keep Stall=1 in every state except IDLE, and in DONE or in a COMPARE hit.
REQ-018 SHALL make Done a single-cycle pulse; the processor holds its inputs stable while Stall=1.
REQ-019 SHALL for Rd&Wr both high or Addr[0]=1 in IDLE: assert err for 1 cycle, perform no access, and change no state.
REQ-020 SHALL keep DataOut at 0 except in the cycle Done is asserted for a load.

Reset
REQ-021 SHALL on rst=0 immediately force state IDLE, clear all valid/dirty bits and counters, and drive every output to 0; an in-flight memory transfer is abandoned and data arrays keep their contents.

Configuration
REQ-022 SHALL with CACHE_STATS_EN defined increment hit_count on each COMPARE hit and miss_count on each COMPARE miss, each saturating at 16'hFFFF.
REQ-023 SHALL without CACHE_STATS_EN tie hit_count and miss_count to 0 with no counter flops.

Structure
REQ-024 SHALL place the FSM state enum and the TAG_W=9, INDEX_W=4, OFFSET_W=2, LINES=16 and MEM_LAT=2 constants in the shared package mem_sys_pkg.
REQ-025 SHALL put the tag/valid/dirty/data storage in the single sub-module cache_array, with the FSM and counters in mem_sys_ctrl.

Verification
REQ-026 SHALL verify: after reset, load 0x0040 -> miss, 4 mem_rd at 0x0040..0x0046, Done at cycle 8, DataOut=mem[0x0040], CacheHit=0.
REQ-027 SHALL verify: repeat load 0x0042 -> Done at cycle 1, CacheHit=1, no mem_rd/mem_wr.
REQ-028 SHALL verify: store 0xBEEF at 0x0040, then load 0x0840 (same index, new tag) -> 4 mem_wr writing 0xBEEF first, then 4 mem_rd, Done at cycle 12.
REQ-029 SHALL verify: mem_stall high for 3 cycles during ALLOCATE word 1 -> Done delayed exactly 3 cycles, data correct.
REQ-030 SHALL verify: Rd=Wr=1 at 0x0010 -> err pulse, no Done, no memory traffic; Addr=0x0011 -> same result.
REQ-031 SHALL verify: rst low mid-WRITEBACK -> outputs 0 immediately, next load of the same address misses.

Source files
------------

// File: rtl/mem_sys_pkg.sv
//==============================================================================
// mem_sys_pkg : shared geometry, latency and FSM state encodings for mem_sys
// Revision    : 1.0
//==============================================================================
`default_nettype none

package mem_sys_pkg;

  localparam int TAG_W    = 9;
  localparam int INDEX_W  = 4;
  localparam int OFFSET_W = 2;
  localparam int LINES    = 16;
  localparam int MEM_LAT  = 2;
  localparam int WORDS    = 1 << OFFSET_W;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] COMPARE   = 3'd1;
  localparam logic [2:0] WRITEBACK = 3'd2;
  localparam logic [2:0] ALLOCATE  = 3'd3;
  localparam logic [2:0] DONE      = 3'd4;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cache_array.sv
//==============================================================================
// cache_array : direct-mapped tag/valid/dirty/data storage, one line per index
// Revision    : 1.0
//==============================================================================
`default_nettype none

module cache_array
  import mem_sys_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [INDEX_W-1:0]  index,
  input  logic [OFFSET_W-1:0] rd_word,
  output logic [TAG_W-1:0]    tag,
  output logic                valid,
  output logic                dirty,
  output logic [15:0]         rdata,
  input  logic                wr_en,
  input  logic [OFFSET_W-1:0] wr_word,
  input  logic [15:0]         wdata,
  input  logic                set_dirty,
  input  logic                install,
  input  logic [TAG_W-1:0]    install_tag
);

  logic [TAG_W-1:0] tags [LINES];
  logic [15:0]      data [LINES*WORDS];
  logic [LINES-1:0] valid_bits;
  logic [LINES-1:0] dirty_bits;

  assign tag   = tags[index];
  assign valid = valid_bits[index];
  assign dirty = dirty_bits[index];
  assign rdata = data[{index, rd_word}];

  // Tags and data are not reset: only the valid bits decide what is cached.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data[{index, wr_word}] <= wdata;
    end
    if (install) begin
      tags[index] <= install_tag;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_bits <= '0;
      dirty_bits <= '0;
    end else if (install) begin
      valid_bits[index] <= 1'b1;
      dirty_bits[index] <= 1'b0;
    end else if (set_dirty) begin
      dirty_bits[index] <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_sys_ctrl.sv
//==============================================================================
// mem_sys_ctrl : write-back, write-allocate cache controller (16 x 4 words)
//                Optional hit/miss statistics: define CACHE_STATS_EN
// Revision     : 1.0
//==============================================================================
`default_nettype none

module mem_sys_ctrl
  import mem_sys_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit,
  output logic        err,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_out,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [15:0] mem_data_in,
  input  logic        mem_stall,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);

  logic [2:0]         state;
  logic [15:1]        req_addr;
  logic [15:0]        req_data;
  logic               req_rd;
  logic               req_wr;
  logic [2:0]         issue_cnt;
  logic [1:0]         cap_cnt;
  logic [MEM_LAT-1:0] lat_pipe;
  logic               err_q;

  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_index;
  logic [OFFSET_W-1:0] req_off;
  logic [TAG_W-1:0]    line_tag;
  logic                line_valid;
  logic                line_dirty;
  logic [15:0]         line_rdata;

  logic hit, cmp_hit, wb_issue, al_issue, accept_rd, capture, last_capture;
  logic access_now, store_now, req_ok, req_bad;

  assign req_tag   = req_addr[15:7];
  assign req_index = req_addr[6:3];
  assign req_off   = req_addr[2:1];

  assign hit          = line_valid && (line_tag == req_tag);
  assign cmp_hit      = (state == COMPARE) && hit;
  assign wb_issue     = (state == WRITEBACK);
  assign al_issue     = (state == ALLOCATE) && !issue_cnt[2];
  assign accept_rd    = al_issue && !mem_stall;
  assign capture      = (state == ALLOCATE) && lat_pipe[MEM_LAT-1];
  assign last_capture = capture && (cap_cnt == 2'd3);
  assign access_now   = cmp_hit || (state == DONE);
  assign store_now    = access_now && req_wr;

  // An odd address is only an error when a request accompanies it.
  assign req_ok  = (Rd ^ Wr) && !Addr[0];
  assign req_bad = (Rd || Wr) && !req_ok;

  cache_array u_array (
    .clk         (clk),
    .rst         (rst),
    .index       (req_index),
    .rd_word     (wb_issue ? issue_cnt[1:0] : req_off),
    .tag         (line_tag),
    .valid       (line_valid),
    .dirty       (line_dirty),
    .rdata       (line_rdata),
    .wr_en       (capture || store_now),
    .wr_word     (capture ? cap_cnt : req_off),
    .wdata       (capture ? mem_data_in : req_data),
    .set_dirty   (store_now),
    .install     (last_capture),
    .install_tag (req_tag)
  );

  assign Done         = access_now;
  assign CacheHit     = cmp_hit;
  assign Stall        = (state != IDLE) && !access_now;
  assign DataOut      = (access_now && req_rd) ? line_rdata : 16'h0000;
  assign err          = err_q;
  assign mem_wr       = wb_issue;
  assign mem_rd       = al_issue;
  assign mem_data_out = wb_issue ? line_rdata : 16'h0000;
  assign mem_addr     = wb_issue ? {line_tag, req_index, issue_cnt[1:0], 1'b0} :
                        al_issue ? {req_tag,  req_index, issue_cnt[1:0], 1'b0} :
                                   16'h0000;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      req_addr  <= '0;
      req_data  <= '0;
      req_rd    <= 1'b0;
      req_wr    <= 1'b0;
      issue_cnt <= '0;
      cap_cnt   <= '0;
      lat_pipe  <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q    <= 1'b0;
      // Captures are timed from accepted issues, so a stall only delays new reads.
      lat_pipe <= {lat_pipe[MEM_LAT-2:0], accept_rd};
      case (state)
        IDLE: begin
          if (req_ok) begin
            req_addr <= Addr[15:1];
            req_data <= DataIn;
            req_rd   <= Rd;
            req_wr   <= Wr;
            state    <= COMPARE;
          end else if (req_bad) begin
            err_q <= 1'b1;
          end
        end
        COMPARE: begin
          issue_cnt <= '0;
          cap_cnt   <= '0;
          if (hit) begin
            state <= IDLE;
          end else if (line_valid && line_dirty) begin
            state <= WRITEBACK;
          end else begin
            state <= ALLOCATE;
          end
        end
        WRITEBACK: begin
          if (!mem_stall) begin
            if (issue_cnt[1:0] == 2'd3) begin
              issue_cnt <= '0;
              state     <= ALLOCATE;
            end else begin
              issue_cnt <= issue_cnt + 3'd1;
            end
          end
        end
        ALLOCATE: begin
          if (accept_rd) begin
            issue_cnt <= issue_cnt + 3'd1;
          end
          if (capture) begin
            cap_cnt <= cap_cnt + 2'd1;
          end
          if (last_capture) begin
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  logic [15:0] hits_q;
  logic [15:0] misses_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      if (cmp_hit) begin
        hits_q <= sat_inc(hits_q);
      end
      if ((state == COMPARE) && !hit) begin
        misses_q <= sat_inc(misses_q);
      end
    end
  end

  assign hit_count  = hits_q;
  assign miss_count = misses_q;
`else
  assign hit_count  = 16'h0000;
  assign miss_count = 16'h0000;
`endif

endmodule

`default_nettype wire
